// File: rtl/tinyriscv_pkg.sv
// ---------------------------------------------------------------------------
// tinyriscv_pkg
//   Shared types and constants for the APB4 two-master arbiter (apb_arb2).
//   Holds the APB bus widths used by apb4_intf, the arbiter FSM state enum,
//   the one-hot grant encoding and the watchdog counter width helper.
// ---------------------------------------------------------------------------
package tinyriscv_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    // Arbiter bus-phase state
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_e;

    // One-hot grant: bit 0 = m0, bit 1 = m1, all-zero = nobody granted
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } apb_arb_gnt_e;

    // Watchdog counter width: ceil(log2(timeout_cyc+1)); a disabled
    // watchdog still gets one bit so the declaration stays legal.
    function automatic int wdog_cnt_w(input int timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/apb4_intf.sv
// ---------------------------------------------------------------------------
// apb4_intf
//   APB4 signal bundle.
//   modport master : drives PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB,
//                    receives PRDATA/PREADY/PSLVERR
//   modport slave  : the reverse view
// ---------------------------------------------------------------------------
interface apb4_intf;
    import tinyriscv_pkg::*;

    logic [APB_ADDR_W-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_STRB_W-1:0] PSTRB;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_arb2.sv
// ---------------------------------------------------------------------------
// apb_arb2
//   Two-requester APB4 arbiter in front of a single downstream APB4 bus.
//   m0 (instruction fetch) and m1 (load/store) each present a complete APB
//   request by raising PSEL; the arbiter picks one in IDLE, runs the
//   SETUP/ACCESS phases on s, and returns the response to the winner only.
//   The loser sees PREADY=0 (wait states) until its own turn.
//
// Ports
//   PCLK     : clock, all state changes on rising edge
//   PRESETn  : asynchronous active-low reset
//   m0       : apb4_intf.slave  - requester 0, wins fixed-priority ties
//   m1       : apb4_intf.slave  - requester 1
//   s        : apb4_intf.master - shared downstream bus
//
// Parameters
//   TIMEOUT_CYC : ACCESS-phase watchdog limit in cycles, 0 disables it
//
// Build options
//   APB_ARB2_RR_EN : when defined, simultaneous requests alternate
//                    (round robin); otherwise m0 always wins a tie.
// ---------------------------------------------------------------------------
module apb_arb2
    import tinyriscv_pkg::*;
#(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic     PCLK,
    input  logic     PRESETn,
    apb4_intf.slave  m0,
    apb4_intf.slave  m1,
    apb4_intf.master s
);

    localparam int              CNT_W    = wdog_cnt_w(TIMEOUT_CYC);
    localparam bit              WDOG_EN  = (TIMEOUT_CYC > 0);
    // Counter value seen in the final allowed ACCESS cycle
    localparam logic [CNT_W-1:0] CNT_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    apb_arb_state_e   state_q, state_d;
    apb_arb_gnt_e     gnt_q, gnt_d;
    apb_arb_gnt_e     pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    logic             sel_m0, sel_m1;

`ifdef APB_ARB2_RR_EN
    // 1 = m1 was granted most recently, so m0 wins the next tie
    logic             last_m1_q;
`endif

    // -----------------------------------------------------------------------
    // Arbitration pick (only consumed in IDLE)
    // -----------------------------------------------------------------------
    always_comb begin
        pick = GNT_NONE;
        if (m0.PSEL && m1.PSEL) begin
`ifdef APB_ARB2_RR_EN
            pick = last_m1_q ? GNT_M0 : GNT_M1;
`else
            pick = GNT_M0;
`endif
        end else if (m0.PSEL) begin
            pick = GNT_M0;
        end else if (m1.PSEL) begin
            pick = GNT_M1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick != GNT_NONE) begin
                    state_d = SETUP;
                    gnt_d   = pick;
                end
            end

            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end

            ACCESS: begin
                if (s.PREADY) begin
                    state_d = IDLE;
                    gnt_d   = GNT_NONE;
                end else begin
                    // Last allowed wait cycle: complete to the requester
                    // with an error instead of hanging the bus forever.
                    if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                        gnt_d   = GNT_NONE;
                    end
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef APB_ARB2_RR_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_m1_q <= 1'b1;
        end else if ((state_q == IDLE) && (pick != GNT_NONE)) begin
            last_m1_q <= (pick == GNT_M1);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Bus outputs: everything is decoded from registered state, so reset
    // silences both sides of the arbiter in the same cycle.
    // -----------------------------------------------------------------------
    assign sel_m0 = (state_q != IDLE) && (gnt_q == GNT_M0);
    assign sel_m1 = (state_q != IDLE) && (gnt_q == GNT_M1);

    assign s.PSEL    = (state_q != IDLE);
    assign s.PENABLE = (state_q == ACCESS);

    assign s.PADDR  = sel_m0 ? m0.PADDR  : (sel_m1 ? m1.PADDR  : '0);
    assign s.PWRITE = sel_m0 ? m0.PWRITE : (sel_m1 ? m1.PWRITE : 1'b0);
    assign s.PWDATA = sel_m0 ? m0.PWDATA : (sel_m1 ? m1.PWDATA : '0);
    assign s.PSTRB  = sel_m0 ? m0.PSTRB  : (sel_m1 ? m1.PSTRB  : '0);

    assign m0.PREADY  = sel_m0 && (state_q == ACCESS) && (s.PREADY || timeout);
    assign m0.PRDATA  = sel_m0 ? s.PRDATA : '0;
    assign m0.PSLVERR = sel_m0 && (s.PSLVERR || timeout);

    assign m1.PREADY  = sel_m1 && (state_q == ACCESS) && (s.PREADY || timeout);
    assign m1.PRDATA  = sel_m1 ? s.PRDATA : '0;
    assign m1.PSLVERR = sel_m1 && (s.PSLVERR || timeout);

endmodule

// File: tb/tb_apb_arb2.sv
module tb_apb_arb2;
    import tinyriscv_pkg::*;

    localparam int TO_CYC = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    apb4_intf m0_if ();
    apb4_intf m1_if ();
    apb4_intf s_if ();

    apb_arb2 #(.TIMEOUT_CYC(TO_CYC)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    // Reference model state: 1 = m1 was the most recent grant
    bit last_m1 = 1'b1;

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_req(input int idx, input bit sel, input txn_t t);
        if (idx == 0) begin
            m0_if.PSEL = sel;     m0_if.PENABLE = 1'b0;
            m0_if.PADDR = t.addr; m0_if.PWRITE = t.wr;
            m0_if.PWDATA = t.wdata; m0_if.PSTRB = t.strb;
        end else begin
            m1_if.PSEL = sel;     m1_if.PENABLE = 1'b0;
            m1_if.PADDR = t.addr; m1_if.PWRITE = t.wr;
            m1_if.PWDATA = t.wdata; m1_if.PSTRB = t.strb;
        end
    endtask

    // Winner of an arbitration decision, from the priority rule
    function automatic int exp_winner(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef APB_ARB2_RR_EN
            return last_m1 ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    // One arbitration round starting in an IDLE cycle: every requester in
    // the round is served in rule order, each with its own wait count.
    task automatic do_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1,
                            input int w0, input int w1, input logic [31:0] rd_last);
        txn_t        tx[2];
        int          w[2];
        int          order[$];
        int          g;
        logic [31:0] rd;
        logic        err;
        logic        g_rdy, o_rdy;
        logic [31:0] g_rd, o_rd;
        logic        g_err, o_err;
        tx[0] = t0; tx[1] = t1; w[0] = w0; w[1] = w1;
        drive_req(0, r0, t0);
        drive_req(1, r1, t1);
        #1;
        n_checks++;
        if (s_if.PSEL !== 1'b0) begin
            n_errors++; $display("FAIL idle_psel: got %b expected 0", s_if.PSEL);
        end
        g = exp_winner(r0, r1);
        order.push_back(g);
        if (r0 && r1) order.push_back(1 - g);
        foreach (order[i]) begin
            g = order[i];
            // SETUP cycle
            tick;
            s_if.PREADY = 1'b0; s_if.PRDATA = $urandom; s_if.PSLVERR = 1'b0;
            #1;
            n_checks++;
            if ({s_if.PSEL, s_if.PENABLE} !== 2'b10) begin
                n_errors++; $display("FAIL setup_ctl: got %b expected 10", {s_if.PSEL, s_if.PENABLE});
            end
            n_checks++;
            if ({s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB} !== tx[g]) begin
                n_errors++; $display("FAIL setup_mux m%0d: got %h expected %h", g,
                    {s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB}, tx[g]);
            end
            n_checks++;
            if ({m0_if.PREADY, m1_if.PREADY} !== 2'b00) begin
                n_errors++; $display("FAIL setup_ready: got %b expected 00", {m0_if.PREADY, m1_if.PREADY});
            end
            // ACCESS cycles: w wait states then ready
            for (int k = 0; k <= w[g]; k++) begin
                tick;
                rd  = (k == w[g]) ? rd_last : $urandom;
                err = 1'($urandom_range(0, 1));
                s_if.PREADY = (k == w[g]); s_if.PRDATA = rd; s_if.PSLVERR = err;
                #1;
                g_rdy = (g == 0) ? m0_if.PREADY  : m1_if.PREADY;
                g_rd  = (g == 0) ? m0_if.PRDATA  : m1_if.PRDATA;
                g_err = (g == 0) ? m0_if.PSLVERR : m1_if.PSLVERR;
                o_rdy = (g == 0) ? m1_if.PREADY  : m0_if.PREADY;
                o_rd  = (g == 0) ? m1_if.PRDATA  : m0_if.PRDATA;
                o_err = (g == 0) ? m1_if.PSLVERR : m0_if.PSLVERR;
                n_checks++;
                if ({s_if.PSEL, s_if.PENABLE} !== 2'b11) begin
                    n_errors++; $display("FAIL access_ctl: got %b expected 11", {s_if.PSEL, s_if.PENABLE});
                end
                n_checks++;
                if ({s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB} !== tx[g]) begin
                    n_errors++; $display("FAIL access_mux m%0d: got %h expected %h", g,
                        {s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB}, tx[g]);
                end
                n_checks++;
                if (g_rdy !== (k == w[g])) begin
                    n_errors++; $display("FAIL gnt_ready m%0d cyc%0d: got %b expected %b", g, k, g_rdy, (k == w[g]));
                end
                n_checks++;
                if ({g_rd, g_err} !== {rd, err}) begin
                    n_errors++; $display("FAIL gnt_resp m%0d: got %h/%b expected %h/%b", g, g_rd, g_err, rd, err);
                end
                n_checks++;
                if ({o_rdy, o_rd, o_err} !== '0) begin
                    n_errors++; $display("FAIL other_quiet m%0d: got %b/%h/%b expected 0", 1 - g, o_rdy, o_rd, o_err);
                end
            end
            last_m1 = (g == 1);
            // IDLE cycle: the finished requester withdraws
            tick;
            drive_req(g, 1'b0, tx[g]);
            s_if.PREADY = 1'b0; s_if.PSLVERR = 1'b0;
            #1;
            n_checks++;
            if ({s_if.PSEL, s_if.PENABLE, s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB} !== '0) begin
                n_errors++; $display("FAIL idle_bus: got %h expected 0",
                    {s_if.PSEL, s_if.PENABLE, s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB});
            end
            n_checks++;
            if ({m0_if.PREADY, m1_if.PREADY} !== 2'b00) begin
                n_errors++; $display("FAIL idle_ready: got %b expected 00", {m0_if.PREADY, m1_if.PREADY});
            end
        end
    endtask

    task automatic test_reset;
        txn_t t;
        t = '{addr: 32'hFFFF_FFFC, wr: 1'b1, wdata: 32'hFFFF_FFFF, strb: 4'hF};
        PRESETn = 1'b0;
        drive_req(0, 1'b1, t);
        drive_req(1, 1'b1, t);
        s_if.PREADY = 1'b1; s_if.PRDATA = 32'hFFFF_FFFF; s_if.PSLVERR = 1'b1;
        repeat (3) tick;
        n_checks++;
        if ({s_if.PSEL, s_if.PENABLE, s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB} !== '0) begin
            n_errors++; $display("FAIL reset_bus: got %h expected 0",
                {s_if.PSEL, s_if.PENABLE, s_if.PADDR, s_if.PWRITE, s_if.PWDATA, s_if.PSTRB});
        end
        n_checks++;
        if ({m0_if.PREADY, m0_if.PRDATA, m0_if.PSLVERR} !== '0) begin
            n_errors++; $display("FAIL reset_m0: got %h expected 0", {m0_if.PREADY, m0_if.PRDATA, m0_if.PSLVERR});
        end
        n_checks++;
        if ({m1_if.PREADY, m1_if.PRDATA, m1_if.PSLVERR} !== '0) begin
            n_errors++; $display("FAIL reset_m1: got %h expected 0", {m1_if.PREADY, m1_if.PRDATA, m1_if.PSLVERR});
        end
        drive_req(0, 1'b0, '0);
        drive_req(1, 1'b0, '0);
        s_if.PREADY = 1'b0; s_if.PRDATA = '0; s_if.PSLVERR = 1'b0;
        PRESETn = 1'b1;
        last_m1 = 1'b1;
        tick;
    endtask

    task automatic test_single_m1_write;
        txn_t t1;
        t1 = '{addr: 32'h1000_0004, wr: 1'b1, wdata: 32'hDEAD_BEEF, strb: 4'b1111};
        do_round(1'b0, 1'b1, '0, t1, 0, 0, 32'h0);
    endtask

    task automatic test_simultaneous;
        txn_t t0, t1;
        t0 = '{addr: 32'h0000_0010, wr: 1'b0, wdata: 32'h0, strb: 4'h0};
        t1 = '{addr: 32'h1000_0000, wr: 1'b0, wdata: 32'h0, strb: 4'h0};
        repeat (3) do_round(1'b1, 1'b1, t0, t1, 0, 0, $urandom);
    endtask

    task automatic test_wait_states;
        txn_t t0;
        t0 = '{addr: 32'h0000_0020, wr: 1'b0, wdata: 32'h0, strb: 4'h0};
        do_round(1'b1, 1'b0, t0, '0, 3, 0, 32'h1234_5678);
    endtask

    task automatic test_back_to_back;
        txn_t t0, t1;
        t0 = '{addr: 32'h0000_0040, wr: 1'b1, wdata: 32'hA5A5_0001, strb: 4'b0011};
        t1 = '{addr: 32'h1000_0040, wr: 1'b1, wdata: 32'h5A5A_0002, strb: 4'b1100};
        do_round(1'b1, 1'b1, t0, t1, 1, 2, $urandom);
        do_round(1'b0, 1'b1, t0, t1, 0, 0, $urandom);
        do_round(1'b1, 1'b1, t0, t1, 0, 1, $urandom);
    endtask

    // Requester PSEL changes during a transfer must not move the grant
    task automatic test_grant_hold;
        txn_t t0, t1;
        t0 = '{addr: 32'h0000_0080, wr: 1'b0, wdata: 32'h0, strb: 4'h0};
        t1 = '{addr: 32'h1000_0080, wr: 1'b1, wdata: 32'hCAFE_F00D, strb: 4'hF};
        drive_req(1, 1'b1, t1);
        tick;
        drive_req(0, 1'b1, t0);
        drive_req(1, 1'b0, t1);
        s_if.PREADY = 1'b0;
        #1;
        n_checks++;
        if (s_if.PADDR !== t1.addr) begin
            n_errors++; $display("FAIL hold_setup_addr: got %h expected %h", s_if.PADDR, t1.addr);
        end
        tick;
        s_if.PREADY = 1'b1; s_if.PRDATA = 32'h0BAD_CAFE; s_if.PSLVERR = 1'b0;
        #1;
        n_checks++;
        if ({m1_if.PREADY, m0_if.PREADY, s_if.PADDR} !== {2'b10, t1.addr}) begin
            n_errors++; $display("FAIL hold_access: got %b%b/%h expected 10/%h",
                m1_if.PREADY, m0_if.PREADY, s_if.PADDR, t1.addr);
        end
        last_m1 = 1'b1;
        tick;
        drive_req(0, 1'b0, t0);
        s_if.PREADY = 1'b0;
        #1;
        tick;
        n_checks++;
        if (s_if.PSEL !== 1'b0) begin
            n_errors++; $display("FAIL hold_no_regrant: got %b expected 0", s_if.PSEL);
        end
    endtask

    task automatic test_timeout;
        txn_t t1;
        t1 = '{addr: 32'h1000_0100, wr: 1'b0, wdata: 32'h0, strb: 4'h0};
        drive_req(1, 1'b1, t1);
        s_if.PREADY = 1'b0; s_if.PSLVERR = 1'b0;
        tick;
        for (int k = 1; k <= TO_CYC; k++) begin
            tick;
            n_checks++;
            if ({s_if.PSEL, s_if.PENABLE, m1_if.PREADY} !== {2'b11, (k == TO_CYC)}) begin
                n_errors++; $display("FAIL timeout_cyc%0d: got %b expected %b", k,
                    {s_if.PSEL, s_if.PENABLE, m1_if.PREADY}, {2'b11, (k == TO_CYC)});
            end
        end
        n_checks++;
        if (m1_if.PSLVERR !== 1'b1) begin
            n_errors++; $display("FAIL timeout_slverr: got %b expected 1", m1_if.PSLVERR);
        end
        last_m1 = 1'b1;
        tick;
        drive_req(1, 1'b0, t1);
        #1;
        n_checks++;
        if ({s_if.PSEL, s_if.PENABLE, m1_if.PREADY} !== 3'b000) begin
            n_errors++; $display("FAIL timeout_release: got %b expected 000",
                {s_if.PSEL, s_if.PENABLE, m1_if.PREADY});
        end
    endtask

    task automatic test_reset_mid;
        txn_t t0;
        t0 = '{addr: 32'h0000_0200, wr: 1'b1, wdata: 32'h1111_2222, strb: 4'hF};
        drive_req(0, 1'b1, t0);
        s_if.PREADY = 1'b0;
        tick;
        tick;
        #2;
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if ({s_if.PSEL, s_if.PENABLE, m0_if.PREADY, m1_if.PREADY} !== 4'b0000) begin
            n_errors++; $display("FAIL reset_mid: got %b expected 0000",
                {s_if.PSEL, s_if.PENABLE, m0_if.PREADY, m1_if.PREADY});
        end
        drive_req(0, 1'b0, t0);
        s_if.PREADY = 1'b1;
        tick;
        n_checks++;
        if ({s_if.PSEL, m0_if.PREADY} !== 2'b00) begin
            n_errors++; $display("FAIL reset_hold: got %b expected 00", {s_if.PSEL, m0_if.PREADY});
        end
        s_if.PREADY = 1'b0;
        PRESETn = 1'b1;
        last_m1 = 1'b1;
        tick;
        n_checks++;
        if ({s_if.PSEL, s_if.PENABLE} !== 2'b00) begin
            n_errors++; $display("FAIL reset_idle: got %b expected 00", {s_if.PSEL, s_if.PENABLE});
        end
        do_round(1'b1, 1'b0, t0, '0, 0, 0, $urandom);
    endtask

    task automatic test_random;
        txn_t t0, t1;
        int   r;
        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(1, 3);
            t0 = '{addr: {1'b0, 31'($urandom)}, wr: 1'($urandom), wdata: $urandom, strb: 4'($urandom)};
            t1 = '{addr: {1'b1, 31'($urandom)}, wr: 1'($urandom), wdata: $urandom, strb: 4'($urandom)};
            do_round(r[0], r[1], t0, t1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        test_reset;
        test_single_m1_write;
        test_reset;
        test_simultaneous;
        test_wait_states;
        test_back_to_back;
        test_grant_hold;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_arb2.md
APB_ARB2 -- requirements
Module: apb_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 0, meaning the ACCESS-phase watchdog limit in cycles (0 = watchdog disabled).
REQ-002 SHALL have port PCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port m0, apb4_intf.slave, bundle: requester 0 (instruction fetch), the higher-priority master.
REQ-005 SHALL have port m1, apb4_intf.slave, bundle: requester 1 (load/store unit).
REQ-006 SHALL have port s, apb4_intf.master, bundle: the shared downstream APB4 bus.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-008 IDLE: a requester with PSEL=1 is pending; with any pending, SHALL register the grant and go to SETUP next cycle; with none pending, SHALL stay in IDLE.
REQ-009 SETUP: s.PSEL=1 and s.PENABLE=0 for exactly one cycle, then SHALL go to ACCESS.
REQ-010 ACCESS: s.PSEL=1 and s.PENABLE=1 until s.PREADY=1, then SHALL go to IDLE the next cycle.
REQ-011 In SETUP/ACCESS, s.PADDR, s.PWRITE, s.PWDATA and s.PSTRB SHALL be combinationally muxed from the granted requester; in IDLE they SHALL be 0.
REQ-012 Granted requester: PREADY = s.PREADY in ACCESS, PRDATA = s.PRDATA, PSLVERR = s.PSLVERR; otherwise PREADY=0, PRDATA=0, PSLVERR=0.
REQ-013 Non-granted requester: PREADY SHALL be held 0 (wait states) whatever its PENABLE.
REQ-014 Grant SHALL be fixed from the IDLE decision until return to IDLE; requester PSEL changes mid-transfer SHALL NOT change it.
REQ-015 Minimum latency: request in IDLE at cycle N gives SETUP at N+1, ACCESS at N+2, requester PREADY at N+2 if the slave has zero wait states.
REQ-016 Back-to-back: the same or another requester pending in the IDLE cycle after completion SHALL start SETUP at the following cycle (one IDLE cycle between transfers).
REQ-017 If TIMEOUT_CYC>0 and s.PREADY stays 0 for TIMEOUT_CYC ACCESS cycles, the FSM SHALL drive the granted requester PREADY=1 and PSLVERR=1 in the last cycle, drop s.PSEL/s.PENABLE, and go to IDLE.
REQ-018 The watchdog counter SHALL be ceil(log2(TIMEOUT_CYC+1)) bits wide, clear on entry to ACCESS, and saturate rather than wrap.

Reset
REQ-019 Asserting PRESETn=0 SHALL immediately force IDLE, clear the grant, set the round-robin pointer to "m1 last", and clear the watchdog counter.
REQ-020 During reset, s.PSEL, s.PENABLE, s.PADDR, s.PWRITE, s.PWDATA, s.PSTRB and all requester PREADY/PRDATA/PSLVERR SHALL be 0.
REQ-021 Reset asserted mid-transfer SHALL abandon the transfer without completing it to either requester.

Configuration
REQ-022 Macro APB_ARB2_RR_EN: when defined, a simultaneous request SHALL be granted to the requester not granted last; the pointer SHALL update on every grant.
REQ-023 Without APB_ARB2_RR_EN, m0 SHALL always win a simultaneous request (fixed priority) and no pointer register SHALL exist.

Structure
REQ-024 The FSM state enum (apb_arb_state_e) and the grant encoding SHALL live in tinyriscv_pkg.
REQ-025 No sub-module SHALL be used; the arbitration pick is inline combinational logic.

Verification
REQ-026 Single m1 write: PADDR=0x1000_0004, PWDATA=0xDEAD_BEEF, PSTRB=4'b1111, slave PREADY=1 immediately -> s sees SETUP at N+1, ACCESS at N+2; m1 PREADY=1 at N+2.
REQ-027 Simultaneous m0 read 0x0000_0010 and m1 read 0x1000_0000 with APB_ARB2_RR_EN, reset pointer -> m0 served first, then m1; m1 PREADY=0 throughout m0's transfer.
REQ-028 Same stimulus repeated 3 times without the macro -> m0 granted all 3 times while m1 waits.
REQ-029 Slave inserts 3 wait states and returns PRDATA=0x1234_5678 -> m0 PREADY asserted only in the 4th ACCESS cycle with PRDATA=0x1234_5678.
REQ-030 TIMEOUT_CYC=8, slave never ready -> after 8 ACCESS cycles m1 gets PREADY=1, PSLVERR=1; s.PSEL=0 on the next cycle.
REQ-031 PRESETn pulsed low during ACCESS -> s.PSEL/PENABLE=0 within the same cycle, no requester PREADY, FSM in IDLE after release.
